branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  ID-stage branch resolver. Consumes the 2-bit operand-forward selects from the branch
//  forwarding unit and picks each branch operand from the RF, the EX result or the WB data.
//  Compares the operands, issues taken/target/IF-flush, and runs a load-use stall FSM.
//  Keeps saturating branch performance counters.
// PARAMETERS
//  DW   32  datapath width (operands, PC, target)
//  CW   16  performance counter width
// PORTS
//  Clk          in   1   clock; all state updates on posedge
//  Rst          in   1   synchronous reset, active-high
//  Branch       in   1   valid branch instruction in ID
//  BrOp         in   3   000 BEQ,001 BNE,010 BLEZ,011 BGTZ,100 BLTZ,101 BGEZ; 110/111 never taken
//  ForwardA1    in   2   op A select: 00 RF, 01 WB data, 10 EX result, 11 RF
//  ForwardB1    in   2   op B select, same encoding
//  rfRdData1    in   DW  RF read port 1
//  rfRdData2    in   DW  RF read port 2
//  EX_AluRes    in   DW  EX-stage ALU result
//  WB_WrData    in   DW  WB-stage write-back data
//  rfReSel1     in   5   ID source reg 1
//  rfReSel2     in   5   ID source reg 2
//  EX_MemRead   in   1   EX instruction is a load
//  EX_rfWeSel   in   5   EX destination reg
//  MEM_MemRead  in   1   MEM instruction is a load
//  MEM_rfWeSel  in   5   MEM destination reg
//  PcPlus4      in   DW  PC+4 of the branch
//  SignImm      in   DW  sign-extended branch offset (in words)
//  Stall        out  1   freeze PC and IF/ID, insert bubble into ID/EX
//  BrTaken      out  1   branch resolved taken (selects BrTarget for the PC)
//  BrTarget     out  DW  PcPlus4 + (SignImm<<2)
//  FlushIF      out  1   kill the instruction in IF (= BrTaken)
//  BrCnt        out  CW  count of resolved branches
//  BrTakenCnt   out  CW  count of taken branches
//  StallCnt     out  CW  count of stall cycles
// BEHAVIOUR
//  Operand mux: OpA/OpB are selected per ForwardA1/ForwardB1 (combinational). Code 11 selects the RF.
//  Hazard detect (comb):
//   hzEX  = Branch & EX_MemRead & EX_rfWeSel!=0 & (EX_rfWeSel==rfReSel1 | ==rfReSel2).
//   hzMEM = same check using MEM_MemRead and MEM_rfWeSel.
//  FSM states: IDLE, HOLD. Reset -> IDLE.
//   IDLE: hzEX -> Stall=1, next HOLD.
//         else hzMEM -> Stall=1, stay IDLE (re-evaluate next cycle).
//         else Stall=0.
//   HOLD: Stall=1 unconditionally, next IDLE. Branch/hazard inputs are ignored in HOLD.
//  A load in EX therefore costs exactly 2 stall cycles; a load in MEM costs 1.
//  Resolution: res = Branch & ~Stall. Only in a res cycle:
//   BrTaken = res & cond(BrOp); otherwise BrTaken=0.
//   cond: BEQ A==B; BNE A!=B; BLEZ A<=0; BGTZ A>0; BLTZ A<0; BGEZ A>=0 (signed, A only).
//  BrTaken, BrTarget and FlushIF are combinational, valid in the res cycle (zero latency).
//  BrTarget is computed every cycle: PcPlus4 + {SignImm[DW-3:0],2'b00}, modulo 2^DW.
//  Counters: BrCnt++ on res; BrTakenCnt++ on BrTaken; StallCnt++ on Stall.
//   Counters saturate at all-ones and do not wrap.
//  Reset: state=IDLE, all counters=0. Combinational outputs follow the inputs.
//   With Branch=0: Stall=0, BrTaken=0, FlushIF=0.
//   Reset asserted in HOLD aborts the stall: Stall=0 in the cycle after reset is sampled.
// TESTING
//  1 BEQ, rfRdData1=rfRdData2=5, Fwd=00 -> BrTaken=1, FlushIF=1.
//    PcPlus4=0x100, SignImm=3 -> BrTarget=0x10C; BrCnt=1, BrTakenCnt=1.
//  2 BNE, ForwardA1=10, EX_AluRes=7, rfRdData2=7 -> BrTaken=0. Repeat with ForwardA1=01,
//    WB_WrData=8 -> BrTaken=1.
//  3 Branch with rfReSel1=4; EX_MemRead=1, EX_rfWeSel=4 -> Stall=1 for exactly 2 cycles.
//    Resolution happens in the 3rd cycle; StallCnt=2.
//  4 Branch; MEM_MemRead=1, MEM_rfWeSel=rfReSel2=9 -> 1 stall cycle. Same case with
//    EX_rfWeSel=0 and EX_MemRead=1 -> no stall.
//  5 Signed cases: BLTZ A=0x80000000 -> taken. BGEZ A=0 -> taken. BGTZ A=0 -> not taken.
//    SignImm=-1, PcPlus4=0x0 -> BrTarget=0xFFFFFFFC.
//  6 Preload BrCnt to 0xFFFF (CW=16), resolve another branch -> holds 0xFFFF.
//    Rst in HOLD -> IDLE, Stall=0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: ID-stage branch resolver bus (operands, hazard info, resolution outputs)
interface branch_resolve_unit_if #(parameter int DW = 32, parameter int CW = 16);
    logic          branch;
    logic [2:0]    br_op;
    logic [1:0]    forward_a1;
    logic [1:0]    forward_b1;
    logic [DW-1:0] rf_rd_data1;
    logic [DW-1:0] rf_rd_data2;
    logic [DW-1:0] ex_alu_res;
    logic [DW-1:0] wb_wr_data;
    logic [4:0]    rf_re_sel1;
    logic [4:0]    rf_re_sel2;
    logic          ex_mem_read;
    logic [4:0]    ex_rf_we_sel;
    logic          mem_mem_read;
    logic [4:0]    mem_rf_we_sel;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] sign_imm;
    logic          stall;
    logic          br_taken;
    logic [DW-1:0] br_target;
    logic          flush_if;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] br_taken_cnt;
    logic [CW-1:0] stall_cnt;

    modport master (
        output branch, br_op, forward_a1, forward_b1, rf_rd_data1, rf_rd_data2, ex_alu_res,
               wb_wr_data, rf_re_sel1, rf_re_sel2, ex_mem_read, ex_rf_we_sel, mem_mem_read,
               mem_rf_we_sel, pc_plus4, sign_imm,
        input  stall, br_taken, br_target, flush_if, br_cnt, br_taken_cnt, stall_cnt
    );

    modport slave (
        input  branch, br_op, forward_a1, forward_b1, rf_rd_data1, rf_rd_data2, ex_alu_res,
               wb_wr_data, rf_re_sel1, rf_re_sel2, ex_mem_read, ex_rf_we_sel, mem_mem_read,
               mem_rf_we_sel, pc_plus4, sign_imm,
        output stall, br_taken, br_target, flush_if, br_cnt, br_taken_cnt, stall_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch resolver with forwarding mux, load-use stall FSM and perf counters
module branch_resolve_unit #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input logic clk_i,
    input logic rst_i,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] op_a, op_b;
    logic          hz_ex, hz_mem, stall, res, cond, a_neg, a_zero;
    logic [CW-1:0] br_cnt_q, br_cnt_d, br_taken_cnt_q, br_taken_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        op_a = bus.forward_a1 == 2'b10 ? bus.ex_alu_res :
               bus.forward_a1 == 2'b01 ? bus.wb_wr_data : bus.rf_rd_data1;
        op_b = bus.forward_b1 == 2'b10 ? bus.ex_alu_res :
               bus.forward_b1 == 2'b01 ? bus.wb_wr_data : bus.rf_rd_data2;
    end

    assign hz_ex  = bus.branch & bus.ex_mem_read & (bus.ex_rf_we_sel != 5'd0) &
                    (bus.ex_rf_we_sel == bus.rf_re_sel1 | bus.ex_rf_we_sel == bus.rf_re_sel2);
    assign hz_mem = bus.branch & bus.mem_mem_read & (bus.mem_rf_we_sel != 5'd0) &
                    (bus.mem_rf_we_sel == bus.rf_re_sel1 | bus.mem_rf_we_sel == bus.rf_re_sel2);

    // An EX load needs two bubbles (HOLD supplies the second); a MEM load needs one.
    always_comb begin
        state_d = IDLE;
        stall   = 1'b0;
        if (state_q == HOLD) begin
            stall = 1'b1;
        end else if (hz_ex) begin
            stall   = 1'b1;
            state_d = HOLD;
        end else if (hz_mem) begin
            stall = 1'b1;
        end
    end

    assign a_neg  = op_a[DW-1];
    assign a_zero = op_a == '0;

    always_comb begin
        cond = bus.br_op == 3'b000 ? op_a == op_b :
               bus.br_op == 3'b001 ? op_a != op_b :
               bus.br_op == 3'b010 ? a_neg | a_zero :
               bus.br_op == 3'b011 ? ~a_neg & ~a_zero :
               bus.br_op == 3'b100 ? a_neg :
               bus.br_op == 3'b101 ? ~a_neg : 1'b0;
    end

    assign res           = bus.branch & ~stall;
    assign bus.stall     = stall;
    assign bus.br_taken  = res & cond;
    assign bus.flush_if  = res & cond;
    assign bus.br_target = bus.pc_plus4 + {bus.sign_imm[DW-3:0], 2'b00};

    always_comb begin
        br_cnt_d       = br_cnt_q + CW'(res & ~&br_cnt_q);
        br_taken_cnt_d = br_taken_cnt_q + CW'(res & cond & ~&br_taken_cnt_q);
        stall_cnt_d    = stall_cnt_q + CW'(stall & ~&stall_cnt_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            br_cnt_q       <= '0;
            br_taken_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            br_cnt_q       <= br_cnt_d;
            br_taken_cnt_q <= br_taken_cnt_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign bus.br_cnt       = br_cnt_q;
    assign bus.br_taken_cnt = br_taken_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + randomized checks of the branch resolver against a behavioural model
module tb_branch_resolve_unit;
    localparam int CMAX = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_owed = 0;
    int   m_br = 0, m_tk = 0, m_st = 0;

    branch_resolve_unit_if #(.DW(32), .CW(16)) bus ();
    branch_resolve_unit #(.DW(32), .CW(16)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel);
        logic [31:0] r;
        r = $urandom;
        return sel == 2'd0 ? 32'd0 : sel == 2'd1 ? 32'h8000_0000 : sel == 2'd2 ? r % 3 - 1 : r;
    endfunction

    function automatic bit taken_rule(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        sa = $signed(a);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd2: return sa <= 0;
            3'd3: return sa > 0;
            3'd4: return sa < 0;
            3'd5: return sa >= 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf);
        return s == 2'd2 ? bus.ex_alu_res : s == 2'd1 ? bus.wb_wr_data : rf;
    endfunction

    task automatic idle();
        bus.branch = 0; bus.br_op = 0; bus.forward_a1 = 0; bus.forward_b1 = 0;
        bus.rf_rd_data1 = 0; bus.rf_rd_data2 = 0; bus.ex_alu_res = 0; bus.wb_wr_data = 0;
        bus.rf_re_sel1 = 0; bus.rf_re_sel2 = 0; bus.ex_mem_read = 0; bus.ex_rf_we_sel = 0;
        bus.mem_mem_read = 0; bus.mem_rf_we_sel = 0; bus.pc_plus4 = 0; bus.sign_imm = 0;
    endtask

    // Inputs are set just after a negedge; check, advance the model over the posedge, return at next negedge.
    task automatic step();
        bit hzx, hzm, st, tk;
        logic [31:0] tgt;
        #1;
        hzx = bus.branch && bus.ex_mem_read && bus.ex_rf_we_sel != 0 &&
              (bus.ex_rf_we_sel == bus.rf_re_sel1 || bus.ex_rf_we_sel == bus.rf_re_sel2);
        hzm = bus.branch && bus.mem_mem_read && bus.mem_rf_we_sel != 0 &&
              (bus.mem_rf_we_sel == bus.rf_re_sel1 || bus.mem_rf_we_sel == bus.rf_re_sel2);
        st  = m_owed > 0 || hzx || hzm;
        tk  = bus.branch && !st &&
              taken_rule(bus.br_op, fwd(bus.forward_a1, bus.rf_rd_data1), fwd(bus.forward_b1, bus.rf_rd_data2));
        tgt = bus.pc_plus4 + bus.sign_imm * 4;
        chk("stall", 32'(bus.stall), 32'(st));
        chk("br_taken", 32'(bus.br_taken), 32'(tk));
        chk("flush_if", 32'(bus.flush_if), 32'(tk));
        chk("br_target", bus.br_target, tgt);
        chk("br_cnt", 32'(bus.br_cnt), m_br);
        chk("br_taken_cnt", 32'(bus.br_taken_cnt), m_tk);
        chk("stall_cnt", 32'(bus.stall_cnt), m_st);
        if (rst) begin
            m_owed = 0; m_br = 0; m_tk = 0; m_st = 0;
        end else begin
            if (bus.branch && !st && m_br < CMAX) m_br++;
            if (tk && m_tk < CMAX) m_tk++;
            if (st && m_st < CMAX) m_st++;
            m_owed = (m_owed == 0 && hzx) ? 1 : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        @(negedge clk);
        step();
        rst = 0;
        // BEQ with equal RF operands
        bus.branch = 1; bus.rf_rd_data1 = 5; bus.rf_rd_data2 = 5; bus.pc_plus4 = 32'h100; bus.sign_imm = 3;
        #1 chk("t1_taken", 32'(bus.br_taken), 1);
        chk("t1_flush", 32'(bus.flush_if), 1);
        chk("t1_target", bus.br_target, 32'h10c);
        step();
        idle();
        #1 chk("t1_br_cnt", 32'(bus.br_cnt), 1);
        chk("t1_tk_cnt", 32'(bus.br_taken_cnt), 1);
        step();
        // BNE with forwarded operand A
        bus.branch = 1; bus.br_op = 1; bus.forward_a1 = 2'b10; bus.ex_alu_res = 7; bus.rf_rd_data2 = 7;
        #1 chk("t2_bne_ex", 32'(bus.br_taken), 0);
        step();
        bus.forward_a1 = 2'b01; bus.wb_wr_data = 8;
        #1 chk("t2_bne_wb", 32'(bus.br_taken), 1);
        step();
        // load in EX: two stall cycles, resolve in the third
        idle();
        bus.branch = 1; bus.rf_re_sel1 = 4; bus.ex_mem_read = 1; bus.ex_rf_we_sel = 4;
        #1 chk("t3_stall1", 32'(bus.stall), 1);
        step();
        #1 chk("t3_stall2", 32'(bus.stall), 1);
        step();
        bus.ex_mem_read = 0;
        #1 chk("t3_resolve", 32'(bus.stall), 0);
        step();
        #1 chk("t3_stall_cnt", 32'(bus.stall_cnt), 2);
        // load in MEM: one stall cycle
        idle();
        bus.branch = 1; bus.rf_re_sel2 = 9; bus.mem_mem_read = 1; bus.mem_rf_we_sel = 9;
        #1 chk("t4_mem_stall", 32'(bus.stall), 1);
        step();
        bus.mem_mem_read = 0;
        #1 chk("t4_mem_done", 32'(bus.stall), 0);
        step();
        bus.ex_mem_read = 1; bus.ex_rf_we_sel = 0;
        #1 chk("t4_r0_nostall", 32'(bus.stall), 0);
        step();
        // signed conditions and negative offset
        idle();
        bus.branch = 1; bus.br_op = 4; bus.rf_rd_data1 = 32'h8000_0000;
        #1 chk("t5_bltz", 32'(bus.br_taken), 1);
        step();
        bus.br_op = 5; bus.rf_rd_data1 = 0;
        #1 chk("t5_bgez", 32'(bus.br_taken), 1);
        step();
        bus.br_op = 3; bus.sign_imm = 32'hffff_ffff; bus.pc_plus4 = 0;
        #1 chk("t5_bgtz", 32'(bus.br_taken), 0);
        chk("t5_target", bus.br_target, 32'hffff_fffc);
        step();
        // reset while in HOLD
        idle();
        bus.branch = 1; bus.rf_re_sel1 = 4; bus.ex_mem_read = 1; bus.ex_rf_we_sel = 4;
        step();
        rst = 1;
        idle();
        #1 chk("t6_hold_stall", 32'(bus.stall), 1);
        step();
        rst = 0;
        #1 chk("t6_rst_abort", 32'(bus.stall), 0);
        step();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 59) == 0;
            bus.branch = $urandom_range(0, 3) != 0;
            bus.br_op = 3'($urandom);
            bus.forward_a1 = 2'($urandom);
            bus.forward_b1 = 2'($urandom);
            bus.rf_rd_data1 = pick(2'($urandom));
            bus.rf_rd_data2 = $urandom_range(0, 1) ? bus.rf_rd_data1 : pick(2'($urandom));
            bus.ex_alu_res = pick(2'($urandom));
            bus.wb_wr_data = $urandom_range(0, 1) ? bus.rf_rd_data2 : pick(2'($urandom));
            bus.rf_re_sel1 = 5'($urandom_range(0, 3));
            bus.rf_re_sel2 = 5'($urandom_range(0, 3));
            bus.ex_mem_read = $urandom_range(0, 2) == 0;
            bus.ex_rf_we_sel = 5'($urandom_range(0, 3));
            bus.mem_mem_read = $urandom_range(0, 2) == 0;
            bus.mem_rf_we_sel = 5'($urandom_range(0, 3));
            bus.pc_plus4 = $urandom;
            bus.sign_imm = $urandom_range(0, 1) ? $urandom : 32'($signed(-$urandom_range(1, 100)));
            step();
        end
        // counter saturation
        rst = 1;
        idle();
        step();
        rst = 0;
        bus.branch = 1;
        for (int i = 0; i < CMAX + 4; i++) step();
        #1 chk("t6_br_sat", 32'(bus.br_cnt), 32'hffff);
        chk("t6_tk_sat", 32'(bus.br_taken_cnt), 32'hffff);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
